// File: rtl/aluout_seq_if.sv
// aluout_seq_if: request and ALUOut-datapath control bundle.
// master = control FSM side, slave = sequencer side.
interface aluout_seq_if #(
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [2:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0]         aluout_sel;
  logic               aluout_load;
  logic [2:0]         shift_ctrl;
  logic [SHAMT_W-1:0] shift_n;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start,
    output op,
    output shamt,
    input  aluout_sel,
    input  aluout_load,
    input  shift_ctrl,
    input  shift_n,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  op,
    input  shamt,
    output aluout_sel,
    output aluout_load,
    output shift_ctrl,
    output shift_n,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/aluout_seq.sv
// aluout_seq: multicycle sequencer for the ALUOut write path.
// Loads and steps the serial shifter, then steers and loads ALUOut.
module aluout_seq #(
  parameter int SHAMT_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  aluout_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_WRITE,
    S_ERR
  } state_e;

  localparam logic [2:0] CTL_NOP  = 3'b000;
  localparam logic [2:0] CTL_LOAD = 3'b001;
  localparam logic [2:0] CTL_SLL  = 3'b010;
  localparam logic [2:0] CTL_SRL  = 3'b011;
  localparam logic [2:0] CTL_SRA  = 3'b100;

  localparam logic [SHAMT_W-1:0] ONE = SHAMT_W'(1);

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;

  logic [1:0]         sel_q, sel_d;
  logic               load_q, load_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [SHAMT_W-1:0] n_q, n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  function automatic logic [1:0] sel_of(input logic [2:0] o);
    logic [1:0] s;
    unique case (o)
      3'b000:  s = 2'b01;
      3'b001:  s = 2'b00;
      3'b010:  s = 2'b11;
      default: s = 2'b10;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] dir_of(input logic [2:0] o);
    logic [2:0] d;
    unique case (o)
      3'b011:  d = CTL_SLL;
      3'b100:  d = CTL_SRL;
      3'b101:  d = CTL_SRA;
      default: d = CTL_NOP;
    endcase
    return d;
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    shamt_d = shamt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          shamt_d = bus.shamt;
          unique case (bus.op)
            3'b000, 3'b001, 3'b010: state_d = S_WRITE;
            3'b011, 3'b100, 3'b101: state_d = S_LOAD;
            default:                state_d = S_ERR;
          endcase
        end
      end
      S_LOAD: begin
        if (shamt_q != '0) begin
          cnt_d   = shamt_q;
          state_d = S_SHIFT;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_SHIFT: begin
        // cnt_q >= 1 here, so the decrement never wraps
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          state_d = S_WRITE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // outputs are decoded from the next state and registered
    sel_d  = 2'b00;
    load_d = 1'b0;
    ctrl_d = CTL_NOP;
    n_d    = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    unique case (state_d)
      S_LOAD: begin
        ctrl_d = CTL_LOAD;
        busy_d = 1'b1;
      end
      S_SHIFT: begin
        ctrl_d = dir_of(op_d);
        n_d    = ONE;
        busy_d = 1'b1;
      end
      S_WRITE: begin
        sel_d  = sel_of(op_d);
        load_d = 1'b1;
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      S_ERR: begin
        err_d  = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      shamt_q <= '0;
      cnt_q   <= '0;
      sel_q   <= 2'b00;
      load_q  <= 1'b0;
      ctrl_q  <= CTL_NOP;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      shamt_q <= shamt_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      ctrl_q  <= ctrl_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.aluout_sel  = sel_q;
  assign bus.aluout_load = load_q;
  assign bus.shift_ctrl  = ctrl_q;
  assign bus.shift_n     = n_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: doc/aluout_seq.md
# aluout_seq

Multicycle sequencer for the ALUOut write path. It accepts one result-producing operation per request. It drives the serial shift register through load and 1-bit shift steps, then steers the ALUOut source mux and pulses the ALUOut register load. It sits between the main control FSM, which issues `start`/`op`, and the ALUOut datapath: the source mux, the shifter and the ALUOut register.

## Interface
- `SHAMT_W`, default 5: width of the shift-amount field.
- `clk`  in  1: system clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high; forces IDLE and output reset values.
- `start`  in  1: request strobe, sampled only in IDLE.
- `op`  in  3: operation, captured with `start`:
  - 000: ALU main
  - 001: ALU aux
  - 010: set (extender)
  - 011: sll
  - 100: srl
  - 101: sra
  - 110/111: invalid
- `shamt`  in  SHAMT_W: shift count, captured with `start`.
- `aluout_sel`  out  2: ALUOut mux selector.
  - 00: ALU aux
  - 01: ALU main
  - 10: shifter
  - 11: extender
- `aluout_load`  out  1: ALUOut register write enable.
- `shift_ctrl`  out  3: shifter command.
  - 000: nop
  - 001: load
  - 010: sll
  - 011: srl
  - 100: sra
- `shift_n`  out  SHAMT_W: per-command shift amount; 1 during shift steps, else 0.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle pulse in the cycle ALUOut is written.
- `err`  out  1: one-cycle pulse for an invalid op.

## Operation
- All outputs are registered Moore outputs decoded from state. Reset values are all 0; `aluout_sel` resets to 00.
- States:
  - IDLE: all outputs 0.
  - LOAD: `shift_ctrl`=001, `busy`=1.
  - SHIFT: `shift_ctrl` = direction code from the latched op, `shift_n`=1, `busy`=1.
  - WRITE: `aluout_sel` from the latched op, `aluout_load`=1, `done`=1, `busy`=1.
  - ERR: `err`=1, `busy`=1, no load.
- IDLE → WRITE on `start` with op 000/001/010.
- IDLE → LOAD on `start` with op 011/100/101.
- IDLE → ERR on `start` with op 110/111.
- LOAD → SHIFT if the latched shamt ≠ 0; the down-counter is loaded with shamt.
- LOAD → WRITE if shamt = 0; `aluout_sel`=10.
- SHIFT: the counter decrements each cycle and the state exits to WRITE after exactly shamt SHIFT cycles.
- WRITE → IDLE; ERR → IDLE.
- Op → `aluout_sel` in WRITE:
  - 000 → 01
  - 001 → 00
  - 010 → 11
  - shifts → 10
- `op`/`shamt` are latched only on an accepted `start`. Input changes during busy have no effect.
- `start` while not in IDLE is ignored; it is not queued. `start` in the same cycle that WRITE/ERR returns to IDLE is also ignored; the earliest accept is the following cycle.
- Maximum shamt (31) gives 31 SHIFT cycles. The counter never wraps.
- Reset mid-operation abandons the op: no `aluout_load`, no `done` afterwards.

## Timing
- `start` is sampled at edge 0.
- ALU main/aux/set: WRITE in cycle 1; total latency 1 cycle.
- Shift, shamt = n > 0: LOAD in cycle 1, SHIFT in cycles 2..n+1, WRITE in cycle n+2.
- Shift, shamt = 0: LOAD in cycle 1, WRITE in cycle 2.
- Invalid op: ERR in cycle 1.
- `busy` is high from cycle 1 through the WRITE/ERR cycle inclusive. It is low in the cycle after.
- `aluout_load` and `done` are always coincident and exactly one cycle wide.
- The throughput floor is one ALU op every 2 cycles.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `start`=1, `op`=000 → all outputs 0 during and the cycle after reset; no load.
- **ALU ops:** `start` with op=000, then op=001, then op=010, each issued when idle → WRITE 1 cycle after each start, with `aluout_sel` = 01, 00, 11 respectively. `aluout_load`=`done`=1 for one cycle each.
- **srl, shamt=3:**
  - cycle 1: `shift_ctrl`=001.
  - cycles 2–4: `shift_ctrl`=011, `shift_n`=1.
  - cycle 5: `aluout_sel`=10, `aluout_load`=1.
  - `busy` high in cycles 1–5.
- **sll with shamt=0:** LOAD then WRITE in cycle 2, no SHIFT cycles.
- **sra with shamt=31:** 31 SHIFT cycles with `shift_ctrl`=100, WRITE in cycle 33.
- **Interference and invalid op:**
  - `start` with op=000 issued during the SHIFT of an sll with shamt=2 → ignored; exactly one `done` occurs.
  - `op` changed mid-shift → the result still selects the original direction.
  - op=111 → `err` pulses in cycle 1, no `aluout_load`, idle in cycle 2.
  - `reset` asserted in the second SHIFT cycle of shamt=5 → IDLE next cycle, no `done`.
